// File: rtl/diff_in_edge_meter.sv
// diff_in_edge_meter: synchronize, glitch-filter and measure an asynchronous differential-buffer input
// Ports: i_mclk/i_mrst clock and sync active-high reset; i_din async input; i_en measurement enable;
//   i_window window length minus 1; o_level/o_rise/o_fall filtered level and edge pulses;
//   o_count/o_count_valid/o_overflow per-window rising-edge count; o_lost loss of activity;
//   o_period/o_period_valid rise-to-rise interval, built only with DIFF_IN_MON_PERIOD_EN defined.
module diff_in_edge_meter #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 3,
    parameter int WINDOW_BITS  = 16,
    parameter int COUNT_BITS   = 16,
    parameter int LOSS_WINDOWS = 2
) (
    input  logic                   i_mclk,
    input  logic                   i_mrst,
    input  logic                   i_din,
    input  logic                   i_en,
    input  logic [WINDOW_BITS-1:0] i_window,
    output logic                   o_level,
    output logic                   o_rise,
    output logic                   o_fall,
    output logic [COUNT_BITS-1:0]  o_count,
    output logic                   o_count_valid,
    output logic                   o_overflow,
    output logic                   o_lost,
    output logic [COUNT_BITS-1:0]  o_period,
    output logic                   o_period_valid
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [3:0] LW = 4'(LOSS_WINDOWS);
    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILTER_LEN-1:0]  w_nh;
    logic [WINDOW_BITS-1:0] r_dcnt;
    logic [COUNT_BITS-1:0]  r_acc, w_sum, w_cnt;
    logic                   r_sat, w_carry;
    logic [3:0]             r_zcnt, w_zinc;
    always_ff @(posedge i_mclk)
        r_sync <= i_mrst ? '0 : {r_sync[SYNC_STAGES-2:0], i_din};
    // w_nh is the history including the sample arriving this cycle, so level moves
    // exactly SYNC_STAGES+FILTER_LEN cycles after a stable din change
    generate
        if (FILTER_LEN == 1) begin : g_nf
            assign w_nh = r_sync[SYNC_STAGES-1];
        end else begin : g_f
            logic [FILTER_LEN-2:0] r_hist;
            always_ff @(posedge i_mclk)
                r_hist <= i_mrst ? '0 : w_nh[FILTER_LEN-2:0];
            assign w_nh = {r_hist, r_sync[SYNC_STAGES-1]};
        end
    endgenerate
    always_ff @(posedge i_mclk) begin
        if (i_mrst) begin
            o_level <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            o_rise  <= !o_level && (&w_nh);
            o_fall  <= o_level && !(|w_nh);
            o_level <= (&w_nh) ? 1'b1 : !(|w_nh) ? 1'b0 : o_level;
        end
    end
    // accumulator plus this cycle's rise, saturating at all-ones
    assign {w_carry, w_sum} = {1'b0, r_acc} + {{COUNT_BITS{1'b0}}, o_rise};
    assign w_cnt  = w_carry ? '1 : w_sum;
    assign w_zinc = (r_zcnt == LW) ? r_zcnt : r_zcnt + 4'd1;
    always_ff @(posedge i_mclk) begin
        if (i_mrst) begin
            r_state       <= IDLE;
            r_dcnt        <= '0;
            r_acc         <= '0;
            r_sat         <= 1'b0;
            r_zcnt        <= '0;
            o_count       <= '0;
            o_count_valid <= 1'b0;
            o_overflow    <= 1'b0;
            o_lost        <= 1'b0;
        end else begin
            o_count_valid <= 1'b0;
            if (r_state == IDLE) begin
                r_acc  <= '0;
                r_sat  <= 1'b0;
                r_zcnt <= '0;
                o_lost <= 1'b0;
                if (i_en) begin
                    r_state <= RUN;
                    r_dcnt  <= i_window;
                end
            end else if (r_dcnt == '0) begin
                // terminal cycle reports even if en has just dropped
                o_count       <= w_cnt;
                o_overflow    <= r_sat | w_carry;
                o_count_valid <= 1'b1;
                r_acc         <= '0;
                r_sat         <= 1'b0;
                r_dcnt        <= i_window;
                r_zcnt        <= (w_cnt == '0) ? w_zinc : '0;
                o_lost        <= (w_cnt == '0) && (w_zinc == LW);
                if (!i_en) r_state <= IDLE;
            end else if (!i_en) begin
                r_state <= IDLE;
                r_acc   <= '0;
                r_sat   <= 1'b0;
                r_zcnt  <= '0;
                o_lost  <= 1'b0;
            end else begin
                r_dcnt <= r_dcnt - WINDOW_BITS'(1);
                r_acc  <= w_cnt;
                r_sat  <= r_sat | w_carry;
            end
        end
    end
`ifdef DIFF_IN_MON_PERIOD_EN
    logic [COUNT_BITS-1:0] r_ival;
    logic                  r_seen;
    always_ff @(posedge i_mclk) begin
        if (i_mrst) begin
            r_ival         <= '0;
            r_seen         <= 1'b0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
        end else begin
            o_period_valid <= 1'b0;
            if (r_state == IDLE) begin
                r_ival <= '0;
                r_seen <= 1'b0;
            end else if (o_rise) begin
                // the first rise in RUN only arms the interval counter
                r_ival <= '0;
                r_seen <= 1'b1;
                if (r_seen) begin
                    o_period       <= (&r_ival) ? r_ival : r_ival + COUNT_BITS'(1);
                    o_period_valid <= 1'b1;
                end
            end else if (!(&r_ival)) begin
                r_ival <= r_ival + COUNT_BITS'(1);
            end
        end
    end
`else
    assign o_period       = '0;
    assign o_period_valid = 1'b0;
`endif
endmodule

// File: tb/tb_diff_in_edge_meter.sv
// tb_diff_in_edge_meter: scoreboard bench for diff_in_edge_meter with directed din patterns
module tb_diff_in_edge_meter;
    localparam int CB = 4;
    typedef struct packed {
        logic [CB-1:0] c;
        logic          ov;
        logic          lost;
    } rep_t;
    logic          clk = 1'b0, rst = 1'b1, din = 1'b0, en = 1'b0;
    logic [15:0]   window = 16'd99;
    logic          o_level, o_rise, o_fall, o_count_valid, o_overflow, o_lost, o_period_valid;
    logic [CB-1:0] o_count, o_period;
    int            vecs = 0, errs = 0, rc = 0, fc = 0, ph = 0, n, b, bf;
    bit            sq_on = 1'b0, pbad = 1'b0;
    rep_t          q[$];
    rep_t          e;
    always #5 clk = ~clk;
    diff_in_edge_meter #(.COUNT_BITS(CB)) dut (
        .i_mclk(clk), .i_mrst(rst), .i_din(din), .i_en(en), .i_window(window),
        .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_count(o_count),
        .o_count_valid(o_count_valid), .o_overflow(o_overflow), .o_lost(o_lost),
        .o_period(o_period), .o_period_valid(o_period_valid)
    );
    task automatic chk(input string nm, input int act, input int req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask
    task automatic exp_rep(input int c, input bit ov, input bit l);
        rep_t r;
        r.c = CB'(c);
        r.ov = ov;
        r.lost = l;
        q.push_back(r);
    endtask
    always @(negedge clk) begin
        if (o_rise) rc++;
        if (o_fall) fc++;
        if (o_count_valid) begin
            if (q.size() == 0) chk("unexpected count_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("count", int'(o_count), int'(e.c));
                chk("overflow", int'(o_overflow), int'(e.ov));
                chk("lost", int'(o_lost), int'(e.lost));
            end
        end
`ifdef DIFF_IN_MON_PERIOD_EN
        if (o_period_valid) chk("period", int'(o_period), 10);
`else
        if (o_period_valid || o_period != '0) pbad = 1'b1;
`endif
    end
    task automatic cyc(input int k);
        repeat (k) begin
            @(negedge clk);
            if (sq_on) begin
                ph = (ph == 9) ? 0 : ph + 1;
                din = (ph < 5);
            end
        end
    endtask
    task automatic start_sq();
        sq_on = 1'b1;
        ph = 0;
        din = 1'b1;
    endtask
    task automatic wait_cv();
        bit ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            cyc(1);
            if (o_count_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("count_valid timeout", 0, 1);
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, " level"}, int'(o_level), 0);
        chk({nm, " rise/fall"}, int'({o_rise, o_fall}), 0);
        chk({nm, " count"}, int'(o_count), 0);
        chk({nm, " flags"}, int'({o_count_valid, o_overflow, o_lost}), 0);
        chk({nm, " period"}, int'({o_period_valid, o_period}), 0);
    endtask
    initial begin
        cyc(3);
        chk_zero("reset");
        rst = 1'b0;
        cyc(10);
        din = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            n++;
            if (o_level) break;
        end
        chk("din-to-level latency", n, 5);
        din = 1'b0;
        cyc(10);
        b = rc;
        din = 1'b1;
        cyc(2);
        din = 1'b0;
        cyc(10);
        chk("2-cycle pulse rises", rc - b, 0);
        chk("2-cycle pulse level", int'(o_level), 0);
        b = rc;
        bf = fc;
        din = 1'b1;
        cyc(3);
        din = 1'b0;
        cyc(10);
        chk("3-cycle pulse rises", rc - b, 1);
        chk("3-cycle pulse falls", fc - bf, 1);
        start_sq();
        cyc(20);
        en = 1'b1;
        repeat (3) exp_rep(10, 1'b0, 1'b0);
        repeat (3) wait_cv();
        en = 1'b0;
        sq_on = 1'b0;
        din = 1'b0;
        cyc(20);
        en = 1'b1;
        exp_rep(0, 1'b0, 1'b0);
        exp_rep(0, 1'b0, 1'b1);
        exp_rep(10, 1'b0, 1'b0);
        wait_cv();
        wait_cv();
        start_sq();
        wait_cv();
        en = 1'b0;
        cyc(1);
        window = 16'd199;
        en = 1'b1;
        cyc(10);
        window = 16'd49;
        exp_rep(15, 1'b1, 1'b0);
        exp_rep(5, 1'b0, 1'b0);
        exp_rep(5, 1'b0, 1'b0);
        repeat (3) wait_cv();
        en = 1'b0;
        cyc(1);
        window = 16'd99;
        en = 1'b1;
        exp_rep(10, 1'b0, 1'b0);
        wait_cv();
        cyc(50);
        en = 1'b0;
        cyc(150);
        chk("count held after abort", int'(o_count), 10);
        en = 1'b1;
        exp_rep(10, 1'b0, 1'b0);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(1);
            n++;
            if (o_count_valid) break;
        end
        chk("report latency after en", n, 101);
        cyc(30);
        rst = 1'b1;
        cyc(1);
        chk_zero("mid-window reset");
        rst = 1'b0;
        en = 1'b0;
        for (int k = 0; k < 500 && q.size() != 0; k++) cyc(1);
        cyc(2);
        chk("scoreboard drained", q.size(), 0);
`ifndef DIFF_IN_MON_PERIOD_EN
        chk("period tied to 0", int'(pbad), 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/diff_in_edge_meter.md
Name: diff_in_edge_meter

Overview:
- Consumes the single-ended output of a differential input buffer: an asynchronous external clock or strobe, already converted to single-ended.
- Synchronizes that signal into mclk and glitch-filters it.
- Emits a clean level plus rise/fall pulses, counts rising edges over a programmable mclk window, and flags loss of activity.
- Used for clock-presence and frequency checks on sensor and sync inputs ahead of any logic that trusts them.

Parameters:
SYNC_STAGES, 2, synchronizer flop count (legal 2..4).
FILTER_LEN, 3, consecutive equal synchronized samples required to change level (1 = no filtering, legal 1..8).
WINDOW_BITS, 16, width of window length input.
COUNT_BITS, 16, width of edge count output.
LOSS_WINDOWS, 2, consecutive zero-edge windows before lost asserts (legal 1..15).

Ports:
mclk  input  1  system clock; all logic on rising edge.
mrst  input  1  reset, synchronous, active-high.
din  input  1  asynchronous input from the differential buffer.
en  input  1  measurement enable.
window  input  WINDOW_BITS  window length minus 1, in mclk cycles.
level  output  1  filtered, synchronized din.
rise  output  1  one-cycle pulse on level 0->1.
fall  output  1  one-cycle pulse on level 1->0.
count  output  COUNT_BITS  rising edges in the last completed window.
count_valid  output  1  one-cycle pulse when count/overflow update.
overflow  output  1  last completed window saturated.
lost  output  1  no activity for LOSS_WINDOWS windows.
period  output  COUNT_BITS  see Optional Feature.
period_valid  output  1  see Optional Feature.

Behaviour:

Reset:
- mrst=1 clears all sync and filter flops, level, counters, state (IDLE) and every output to 0 on the next mclk edge.
- Reset in mid-window discards the partial window; no count_valid is issued.

Sync and filter:
- din passes through SYNC_STAGES flops, then a FILTER_LEN-deep history register.
- level toggles when all FILTER_LEN history samples equal each other and differ from level.
- rise/fall are registered and asserted in the same cycle that level changes.
- Latency from a stable din change to the level change is exactly SYNC_STAGES+FILTER_LEN mclk cycles.
- Pulses shorter than FILTER_LEN cycles after synchronization never reach level.
- level, rise and fall run regardless of en.

Measurement FSM, states IDLE and RUN:
- IDLE: accumulator is 0. en=1 -> RUN next cycle, and window is loaded into the down-counter.
- RUN, each cycle: rise increments the accumulator, saturating at all-ones and setting a sat flag.
- Window end, when the down-counter is 0:
  - count <= accumulator + that cycle's rise, saturated. An edge on the terminal cycle belongs to the closing window.
  - overflow <= sat; count_valid=1 for one cycle.
  - Accumulator and sat clear; the down-counter reloads from the current window.
  - The window input is sampled only at start and reload.
- window=0 gives a 1-cycle window, with count_valid every cycle.
- en=0 in RUN -> IDLE next cycle. The partial window is discarded with no count_valid; count and overflow hold their last values.
- en=0 on the terminal cycle: that window still completes and reports.

Loss detection:
- A zero-window counter increments on each completed window with count=0, saturating at LOSS_WINDOWS.
- lost=1 while the counter equals LOSS_WINDOWS.
- The first completed window with count>0 clears the counter and lost. Entering IDLE also clears both.
- lost updates in the same cycle as count_valid.

Optional Feature:
DIFF_IN_MON_PERIOD_EN

Defined:
- A free-running interval counter clears on each rise and otherwise increments, saturating.
- On every rise after the first rise since reset or since entering RUN:
  - period <= interval value + 1 (mclk cycles since the previous rise).
  - period_valid pulses for one cycle.
- Active only in RUN.

Undefined:
- period and period_valid are tied to 0.
- Port list unchanged.

Test Plan:
- SYNC_STAGES=2, FILTER_LEN=3, window=99, en=1, din square wave period 10 cycles (5 high/5 low) -> count_valid every 100 cycles, count=10, overflow=0, lost=0; level lags din by exactly 5 cycles.
- din high pulse of 2 mclk cycles, otherwise low -> level stays 0, rise never asserts; a 3-cycle pulse produces exactly one rise and one fall.
- Square wave running, then din held low -> first empty window gives count=0, lost=0; second gives lost=1; restarting din clears lost on the first nonzero window.
- COUNT_BITS=4, window=199, din period 10 -> count=15, overflow=1; then window=49 at the next reload -> count=5, overflow=0.
- en deasserted at cycle 50 of a 100-cycle window -> no count_valid, count holds its prior value 10; en reasserted -> next report after 100 cycles. mrst mid-window -> all outputs 0 next cycle.
- With DIFF_IN_MON_PERIOD_EN, din period 10 -> period=10 with period_valid on every rise except the first after en; without the macro, period=0 and period_valid=0 throughout.
